// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: runs the external expansion step ROUND_COUNT times
// and serves the captured round keys. Define AES_KEY_SCHED_REUSE_EN to skip re-expanding an identical key.
module aes_key_sched_ctrl #(
  parameter int ROUND_COUNT = 10,
  parameter int KEY_W       = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] step_key,
  output logic [7:0]       step_rcon,
  input  logic [KEY_W-1:0] step_next,
  output logic             busy,
  output logic             keys_valid,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_valid,
  output logic             rd_err
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [3:0] LAST = 4'(ROUND_COUNT);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] rk_q [ROUND_COUNT+1];
  logic [KEY_W-1:0] rd_key_q, rd_key_d;
  logic             rd_valid_q, rd_err_q, rd_err_d;
  logic             accept, reuse_hit, load_rk0, step_we, rd_hit;

  function automatic logic [7:0] rcon_lut(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign key_ready  = (state_q != EXPAND);
  assign busy       = (state_q == EXPAND);
  assign keys_valid = (state_q == DONE);
  assign accept     = key_valid && key_ready;

`ifdef AES_KEY_SCHED_REUSE_EN
  assign reuse_hit = (state_q == DONE) && (key_in == rk_q[0]);
`else
  assign reuse_hit = 1'b0;
`endif

  // Step operands come straight from the bank so the external step sees them a full cycle
  assign step_key  = (state_q == EXPAND) ? rk_q[cnt_q - 4'd1] : '0;
  assign step_rcon = (state_q == EXPAND) ? rcon_lut(cnt_q) : 8'h00;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_rk0 = 1'b0;
    step_we  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept && !reuse_hit) begin
          load_rk0 = 1'b1;
          cnt_d    = 4'd1;
          state_d  = EXPAND;
        end
      end
      EXPAND: begin
        step_we = 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads see pre-edge keys_valid, so a read racing a new accept returns the old set
  assign rd_hit   = keys_valid && (rd_idx <= LAST);
  assign rd_key_d = rd_hit ? rk_q[rd_idx] : '0;
  assign rd_err_d = !rd_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_en;
      rd_err_q   <= rd_en && rd_err_d;
      if (rd_en) begin
        rd_key_q <= rd_key_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_rk0) begin
      rk_q[0] <= key_in;
    end
    if (step_we) begin
      rk_q[cnt_q] <= step_next;
    end
  end

  assign rd_key   = rd_key_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: supplies an AES-128 expansion step and checks the
// controller against a queue-free array model of the full key schedule.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] step_key;
  logic [7:0]   step_rcon;
  logic [127:0] step_next;
  logic         busy;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_valid;
  logic         rd_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] m_rk [11];
  bit           m_valid = 1'b0;

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes_key_sched_ctrl dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .step_key(step_key), .step_rcon(step_rcon), .step_next(step_next), .busy(busy),
    .keys_valid(keys_valid), .rd_en(rd_en), .rd_idx(rd_idx), .rd_key(rd_key),
    .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, p, e, b;
    r = 8'h01; p = a; e = 8'hfe;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_step(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    w0 = prev[127:96]; w1 = prev[95:64]; w2 = prev[63:32]; w3 = prev[31:0];
    rot = {w3[23:0], w3[31:24]};
    t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
    n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Round constant i is x^(i-1) in GF(2^8)
  function automatic logic [7:0] rcon_of(input int i);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < i; j++) r = gmul(r, 8'h02);
    return r;
  endfunction

  assign step_next = aes_step(step_key, step_rcon);

  task automatic model_expand(input logic [127:0] k);
    m_rk[0] = k;
    for (int i = 1; i <= 10; i++) m_rk[i] = aes_step(m_rk[i-1], rcon_of(i));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [3:0] idx, output logic [127:0] k, output logic v, output logic e);
    rd_en = 1'b1; rd_idx = idx;
    tick();
    rd_en = 1'b0;
    k = rd_key; v = rd_valid; e = rd_err;
  endtask

  task automatic load_key(input logic [127:0] k, input int inject_at);
    int w;
    w = 0;
    while (!key_ready && w < 30) begin tick(); w++; end
    n_checks++;
    if (!key_ready) begin n_fail++; $display("FAIL load_wait key_ready=%b required 1", key_ready); end
    model_expand(k);
    m_valid = 1'b0;
    key_valid = 1'b1; key_in = k;
    tick();
    key_valid = 1'b0; key_in = {$urandom, $urandom, $urandom, $urandom};
    for (int c = 1; c <= 10; c++) begin
      n_checks++;
      if ({key_ready, busy, keys_valid} !== 3'b010 || step_rcon !== rcon_of(c) || step_key !== m_rk[c-1]) begin
        n_fail++;
        $display("FAIL expand_cycle%0d rdy/busy/kv=%b rcon=%h key=%h required 010 rcon=%h key=%h",
                 c, {key_ready, busy, keys_valid}, step_rcon, step_key, rcon_of(c), m_rk[c-1]);
      end
      if (c == inject_at) begin key_valid = 1'b1; key_in = ~k; end
      tick();
      key_valid = 1'b0;
    end
    n_checks++;
    if ({key_ready, busy, keys_valid} !== 3'b101 || step_rcon !== 8'h00) begin
      n_fail++;
      $display("FAIL expand_done rdy/busy/kv=%b rcon=%h required 101 rcon=00", {key_ready, busy, keys_valid}, step_rcon);
    end
    m_valid = 1'b1;
  endtask

  task automatic test_random_reads(input int n);
    logic [127:0] k, ek;
    logic v, e, ee;
    logic [3:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = 4'($urandom_range(0, 15));
      ee = !(m_valid && idx <= 4'd10);
      ek = ee ? 128'h0 : m_rk[idx];
      do_read(idx, k, v, e);
      n_checks++;
      if (v !== 1'b1 || e !== ee || k !== ek) begin
        n_fail++;
        $display("FAIL rand_read idx=%0d v=%b e=%b key=%h required v=1 e=%b key=%h", idx, v, e, k, ee, ek);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_checks++;
    if ({key_ready, busy, keys_valid} !== 3'b100) begin
      n_fail++; $display("FAIL reset_ctrl rdy/busy/kv=%b required 100", {key_ready, busy, keys_valid});
    end
    n_checks++;
    if ({rd_valid, rd_err} !== 2'b00 || rd_key !== 128'h0) begin
      n_fail++; $display("FAIL reset_rd v/e=%b key=%h required 00 key=0", {rd_valid, rd_err}, rd_key);
    end
    n_checks++;
    if (step_rcon !== 8'h00 || step_key !== 128'h0) begin
      n_fail++; $display("FAIL reset_step rcon=%h key=%h required 0", step_rcon, step_key);
    end
  endtask

  task automatic test_fips_vector();
    logic [127:0] k;
    logic v, e;
    load_key(K1, 0);
    do_read(4'd1, k, v, e);
    n_checks++;
    if (k !== K1_RK1 || {v, e} !== 2'b10) begin n_fail++; $display("FAIL fips_rk1 key=%h v/e=%b required %h 10", k, {v, e}, K1_RK1); end
    do_read(4'd10, k, v, e);
    n_checks++;
    if (k !== K1_RK10 || {v, e} !== 2'b10) begin n_fail++; $display("FAIL fips_rk10 key=%h v/e=%b required %h 10", k, {v, e}, K1_RK10); end
    do_read(4'd0, k, v, e);
    n_checks++;
    if (k !== K1 || {v, e} !== 2'b10) begin n_fail++; $display("FAIL fips_rk0 key=%h v/e=%b required %h 10", k, {v, e}, K1); end
    tick();
    n_checks++;
    if ({rd_valid, rd_err} !== 2'b00 || rd_key !== K1) begin
      n_fail++; $display("FAIL rd_hold v/e=%b key=%h required 00 key=%h", {rd_valid, rd_err}, rd_key, K1);
    end
    do_read(4'd11, k, v, e);
    n_checks++;
    if (k !== 128'h0 || {v, e} !== 2'b11) begin n_fail++; $display("FAIL rd_idx11 key=%h v/e=%b required 0 11", k, {v, e}); end
    do_read(4'd15, k, v, e);
    n_checks++;
    if (k !== 128'h0 || {v, e} !== 2'b11) begin n_fail++; $display("FAIL rd_idx15 key=%h v/e=%b required 0 11", k, {v, e}); end
  endtask

  task automatic test_rst_mid_expand();
    logic [127:0] k;
    logic v, e;
    key_valid = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
    m_valid = 1'b0;
    tick();
    key_valid = 1'b0;
    tick(); tick(); tick();
    do_read(4'd3, k, v, e);
    n_checks++;
    if (k !== 128'h0 || {v, e} !== 2'b11 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rd_mid_expand key=%h v/e=%b busy=%b required 0 11 busy=1", k, {v, e}, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({key_ready, busy, keys_valid} !== 3'b100 || step_rcon !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid rdy/busy/kv=%b rcon=%h required 100 rcon=00", {key_ready, busy, keys_valid}, step_rcon);
    end
    for (int i = 0; i < 12; i++) begin
      if (keys_valid !== 1'b0) begin
        n_checks++; n_fail++; $display("FAIL rst_partial_valid kv=%b required 0", keys_valid);
      end
      tick();
    end
    load_key(K2, 0);
    do_read(4'd10, k, v, e);
    n_checks++;
    if (k !== K2_RK10 || {v, e} !== 2'b10) begin n_fail++; $display("FAIL k2_rk10 key=%h v/e=%b required %h 10", k, {v, e}, K2_RK10); end
  endtask

  task automatic test_ignore_in_expand();
    load_key({$urandom, $urandom, $urandom, $urandom}, 4);
    test_random_reads(6);
    load_key({$urandom, $urandom, $urandom, $urandom}, 10);
    test_random_reads(4);
  endtask

  task automatic test_read_accept_same_edge();
    logic [127:0] k, old, nk;
    logic v, e;
    logic [3:0] r;
    int n;
    r = 4'($urandom_range(0, 10));
    old = m_rk[r];
    nk = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1; key_in = nk; rd_en = 1'b1; rd_idx = r;
    tick();
    key_valid = 1'b0; rd_en = 1'b0;
    m_valid = 1'b0;
    n_checks++;
    if (rd_key !== old || {rd_valid, rd_err} !== 2'b10 || {busy, keys_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL same_edge_read key=%h v/e=%b busy/kv=%b required %h 10 10", rd_key, {rd_valid, rd_err}, {busy, keys_valid}, old);
    end
    do_read(r, k, v, e);
    n_checks++;
    if (k !== 128'h0 || {v, e} !== 2'b11) begin n_fail++; $display("FAIL post_accept_read key=%h v/e=%b required 0 11", k, {v, e}); end
    n = 0;
    while (!keys_valid && n < 20) begin tick(); n++; end
    n_checks++;
    if (n != 9 || keys_valid !== 1'b1) begin n_fail++; $display("FAIL same_edge_latency cycles=%0d kv=%b required 9 1", n, keys_valid); end
    model_expand(nk);
    m_valid = 1'b1;
    test_random_reads(6);
  endtask

  task automatic test_same_key_reload();
    logic [127:0] k, ek;
    logic v, e;
    ek = m_rk[10];
`ifdef AES_KEY_SCHED_REUSE_EN
    key_valid = 1'b1; key_in = m_rk[0];
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({key_ready, busy, keys_valid} !== 3'b101 || step_rcon !== 8'h00) begin
        n_fail++; $display("FAIL reuse_cycle%0d rdy/busy/kv=%b required 101", i, {key_ready, busy, keys_valid});
      end
      tick();
    end
`else
    load_key(m_rk[0], 0);
`endif
    do_read(4'd10, k, v, e);
    n_checks++;
    if (k !== ek || {v, e} !== 2'b10) begin n_fail++; $display("FAIL same_key_rk10 key=%h v/e=%b required %h 10", k, {v, e}, ek); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      load_key({$urandom, $urandom, $urandom, $urandom}, 0);
      test_random_reads(5);
    end
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_in = '0; rd_en = 1'b0; rd_idx = '0;
    test_reset();
    test_fips_vector();
    test_rst_mid_expand();
    test_ignore_in_expand();
    test_read_accept_same_edge();
    test_same_key_reload();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequences the AES-128 single-round key expansion datapath ten times per cipher key.
- Captures all 11 round keys (rk0..rk10) in an internal register bank.
- Serves round keys to the cipher round engine through a registered read port.
- Sits between the key load interface and the cipher core; the expansion step logic itself stays external.

Parameters:
- ROUND_COUNT, 10, number of expansion steps; the bank holds ROUND_COUNT+1 entries.
- KEY_W, 128, round key width in bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_in  in  KEY_W  cipher key; sampled when key_valid && key_ready
- key_valid  in  1  new key offered
- key_ready  out  1  controller can accept a key
- step_key  out  KEY_W  previous round key driven to the external expansion step
- step_rcon  out  8  round constant for the current step
- step_next  in  KEY_W  expansion step result; combinational from step_key/step_rcon
- busy  out  1  expansion in progress
- keys_valid  out  1  all round keys rk0..rk10 are present and consistent
- rd_en  in  1  read request
- rd_idx  in  4  round key index to read
- rd_key  out  KEY_W  read data
- rd_valid  out  1  read data valid
- rd_err  out  1  read rejected

Behaviour:
- States: IDLE, EXPAND, DONE.
- Reset values: state=IDLE, key_ready=1, busy=0, keys_valid=0, rd_valid=0, rd_err=0, rd_key=0, cnt=0, step_key=0, step_rcon=0. Bank contents are don't-care.
- key_ready is high in IDLE and DONE and low in EXPAND.
- Accept edge E0 (key_valid && key_ready):
  - rk0 <= key_in; cnt <= 1; state <= EXPAND; keys_valid <= 0; busy <= 1.
- EXPAND, each cycle:
  - step_key = rk[cnt-1], step_rcon = RCON[cnt], both combinational from registers.
  - At the edge: rk[cnt] <= step_next; cnt <= cnt+1.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1B,36. step_rcon = 0 outside EXPAND.
- When cnt==ROUND_COUNT at the edge (E10): rk10 stored, state <= DONE, keys_valid <= 1, busy <= 0.
  - Latency from accept to keys_valid high is 10 cycles.
- In DONE a new key is accepted as in IDLE; keys_valid drops on the accept edge.
- key_valid asserted in EXPAND is ignored: no capture and no stall of the current run. The requester holds key_valid until key_ready.
- Reads are one-cycle registered. rd_en at edge N gives rd_valid=1 for the following cycle.
  - If keys_valid==1 and rd_idx<=10: rd_key=rk[rd_idx], rd_err=0.
  - Otherwise (keys_valid==0 or rd_idx>10): rd_key=0, rd_err=1.
  - Without rd_en: rd_valid=0, rd_err=0, rd_key holds its last value.
- Read and accept on the same edge: the read is evaluated with pre-edge keys_valid. If the old set was valid it returns old data; that read completes and subsequent reads error until the new set is done.
- rst in any state, including mid-EXPAND, forces the reset values on the next edge. A partially expanded bank is never marked valid.
- cnt is 4 bits and never exceeds 10.

Optional Feature:
- Macro: AES_KEY_SCHED_REUSE_EN.
- Defined: on accept in DONE where key_in == rk0, the state stays DONE, keys_valid stays 1, busy stays 0 and no step cycles run (zero-cycle reload). A differing key expands normally.
- Undefined: every accepted key is re-expanded in full, 10 cycles.

Test Plan:
- Reset then load key 2b7e151628aed2a6abf7158809cf4f3c -> keys_valid rises exactly 10 cycles after the accept edge; read idx1 -> a0fafe1788542cb123a339392a6c7605; idx10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; idx0 -> the key.
- Monitor step_rcon during expansion -> 01,02,04,08,10,20,40,80,1B,36 on consecutive cycles; key_ready=0 and busy=1 throughout.
- Read idx 11 and idx 15 after DONE -> rd_valid=1, rd_err=1, rd_key=0. Read idx 3 mid-EXPAND -> rd_err=1.
- Assert rst at cnt=5, then load key 000102030405060708090a0b0c0d0e0f -> keys_valid only after a full 10-cycle run; idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
- key_valid pulsed with a different key during EXPAND -> ignored. Key reloaded in DONE -> keys_valid low on the accept edge, then 10 cycles later high with the new key set.
- With AES_KEY_SCHED_REUSE_EN, reload the same key in DONE -> keys_valid never drops and busy stays 0. Without the macro -> a 10-cycle re-expansion with identical results.
